coin_acceptor: RTL and testbench

Upstream front end of the vending machine. It turns the raw coin-chute sensor line into the 2-bit coin code that `vending_machine` samples on every `clk` edge. It synchronises and debounces the sensor, then measures the high-pulse width to classify the coin as 5 or 10 rupee. Each accepted coin appears on `coin` for exactly one cycle; `coin` is 2'b00 at all other times. Invalid, too-short, too-long and jammed pulses are rejected.

---
 rtl/vending_pkg.sv | 18 +
 rtl/coin_acceptor_if.sv | 11 +
 rtl/coin_debounce.sv | 36 +++
 rtl/coin_acceptor.sv | 100 ++++++++++
 tb/tb_coin_acceptor.sv | 149 ++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared vending-machine definitions: coin codes seen by vending_machine and
// the coin_acceptor state encoding.
package vending_pkg;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_5    = 2'b01;
  localparam logic [1:0] COIN_10   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_CLASSIFY,
    ST_JAM,
    ST_HOLDOFF,
    ST_WAIT_LOW
  } acc_state_e;

endpackage

// File: rtl/coin_acceptor_if.sv
// Chute-side bundle of the coin acceptor: raw sensor in, coin code and status out.
interface coin_acceptor_if;
  logic       sensor;
  logic [1:0] coin;
  logic       reject;
  logic       jam;
  logic       busy;

  modport master (output sensor, input coin, reject, jam, busy);
  modport slave  (input sensor, output coin, reject, jam, busy);
endinterface

// File: rtl/coin_debounce.sv
// Two-flop synchroniser plus symmetric debounce filter; rise and fall are
// delayed by the same amount so the high width survives filtering.
module coin_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor,
  output logic f
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic            s1, s2;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      f   <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= sensor;
      s2 <= s1;
      // any sample agreeing with f restarts the run
      if (s2 == f) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DEBOUNCE - 1)) begin
        f   <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end
endmodule

// File: rtl/coin_acceptor.sv
// Coin front end: measures the filtered high-pulse width and emits a one-cycle
// coin code or reject, with jam detection and a post-event holdoff.
module coin_acceptor
  import vending_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int W5_MIN   = 8,
  parameter int W5_MAX   = 15,
  parameter int W10_MIN  = 20,
  parameter int W10_MAX  = 31,
  parameter int HOLDOFF  = 4,
  parameter int CNT_W    = 6
) (
  input  logic clk,
  input  logic rst,
  coin_acceptor_if.slave bus
);
  localparam int HO_W = $clog2(HOLDOFF + 1);

  logic             f;
  acc_state_e       state;
  logic [CNT_W-1:0] wcnt, wnext;
  logic [HO_W-1:0]  hcnt;
  logic [1:0]       coin_r;
  logic             reject_r, jam_r;

  coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb (
    .clk    (clk),
    .rst    (rst),
    .sensor (bus.sensor),
    .f      (f)
  );

  assign wnext = (wcnt == '1) ? wcnt : wcnt + CNT_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wcnt     <= '0;
      hcnt     <= '0;
      coin_r   <= COIN_NONE;
      reject_r <= 1'b0;
      jam_r    <= 1'b0;
    end else begin
      coin_r   <= COIN_NONE;
      reject_r <= 1'b0;
      case (state)
        ST_IDLE: if (f) begin
          wcnt  <= CNT_W'(1);
          state <= ST_MEASURE;
        end
        ST_MEASURE: begin
          if (!f) begin
            state <= ST_CLASSIFY;
          end else begin
            wcnt <= wnext;
            if (wnext > CNT_W'(W10_MAX)) begin
              jam_r <= 1'b1;
              state <= ST_JAM;
            end
          end
        end
        ST_CLASSIFY: begin
          if (wcnt >= CNT_W'(W5_MIN) && wcnt <= CNT_W'(W5_MAX))
            coin_r <= COIN_5;
          else if (wcnt >= CNT_W'(W10_MIN) && wcnt <= CNT_W'(W10_MAX))
            coin_r <= COIN_10;
          else
            reject_r <= 1'b1;
          hcnt  <= '0;
          state <= ST_HOLDOFF;
        end
        ST_JAM: if (!f) begin
          jam_r    <= 1'b0;
          reject_r <= 1'b1;
          hcnt     <= '0;
          state    <= ST_HOLDOFF;
        end
        // the emission cycle plus HOLDOFF dead cycles before f is looked at again
        ST_HOLDOFF: begin
          if (hcnt == HO_W'(HOLDOFF))
            state <= f ? ST_WAIT_LOW : ST_IDLE;
          else
            hcnt <= hcnt + HO_W'(1);
        end
        ST_WAIT_LOW: if (!f) begin
          reject_r <= 1'b1;
          hcnt     <= '0;
          state    <= ST_HOLDOFF;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.coin   = coin_r;
  assign bus.reject = reject_r;
  assign bus.jam    = jam_r;
  assign bus.busy   = (state != ST_IDLE);
endmodule

// File: tb/tb_coin_acceptor.sv
// Pulse-level reference model: each sensor pulse's width decides what the
// outputs must show and on which clock edge; a monitor compares every cycle.
module tb_coin_acceptor;
  import vending_pkg::*;

  localparam int D       = 4;
  localparam int W5_MIN  = 8;
  localparam int W5_MAX  = 15;
  localparam int W10_MIN = 20;
  localparam int W10_MAX = 31;
  localparam int HO      = 4;
  localparam int NCYC    = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  coin_acceptor_if bus ();

  coin_acceptor #(
    .DEBOUNCE(D), .W5_MIN(W5_MIN), .W5_MAX(W5_MAX),
    .W10_MIN(W10_MIN), .W10_MAX(W10_MAX), .HOLDOFF(HO), .CNT_W(6)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // number of rising edges seen so far
  int ecnt = 0;
  always @(posedge clk) ecnt <= ecnt + 1;

  int total = 0;
  int bad   = 0;
  int exp_coin [NCYC];
  int exp_rej  [NCYC];
  int exp_jam  [NCYC];
  int exp_busy [NCYC];   // -1 = not checked on that edge
  bit mon_en = 1'b0;

  task automatic chk(input string tag, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s edge=%0d got=%0d want=%0d", tag, ecnt, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && ecnt < NCYC) begin
      chk("coin",   int'(bus.coin),   exp_coin[ecnt]);
      chk("reject", int'(bus.reject), exp_rej[ecnt]);
      chk("jam",    int'(bus.jam),    exp_jam[ecnt]);
      if (exp_busy[ecnt] >= 0) chk("busy", int'(bus.busy), exp_busy[ecnt]);
    end
  end

  function automatic bit ok(input int i);
    return i >= 0 && i < NCYC;
  endfunction

  // Pulse whose first high sample is edge p0 and first low sample edge e0.
  // f rises D+1 edges after p0; results come D+3 edges after e0, except a jam
  // reject which comes as f's fall is seen (D+2).
  task automatic expect_pulse(input int p0, input int n);
    int e0, ev;
    e0 = p0 + n;
    if (ok(p0)) exp_busy[p0] = 0;
    if (n < D) return;
    if (n > W10_MAX) begin
      for (int e = p0 + D + W10_MAX + 2; e < e0 + D + 2; e++)
        if (ok(e)) exp_jam[e] = 1;
      ev = e0 + D + 2;
      if (ok(ev)) begin exp_rej[ev] = 1; exp_busy[ev] = 1; end
    end else begin
      ev = e0 + D + 3;
      if (ok(ev)) begin
        exp_busy[ev] = 1;
        if (n >= W5_MIN && n <= W5_MAX)        exp_coin[ev] = int'(COIN_5);
        else if (n >= W10_MIN && n <= W10_MAX) exp_coin[ev] = int'(COIN_10);
        else                                   exp_rej[ev]  = 1;
      end
    end
  endtask

  task automatic pulse(input int n, input int gap);
    @(negedge clk);
    expect_pulse(ecnt + 1, n);
    bus.sensor = 1'b1;
    repeat (n) @(negedge clk);
    bus.sensor = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // 10-sample pulse with reset asserted after 'at' high samples for 'len'
  // cycles; fewer than D high samples remain afterwards, so nothing may appear.
  task automatic reset_pulse(input int at, input int len);
    int p0;
    @(negedge clk);
    p0 = ecnt + 1;
    if (ok(p0)) exp_busy[p0] = 0;
    bus.sensor = 1'b1;
    repeat (at) @(negedge clk);
    rst = 1'b1;
    repeat (len) @(negedge clk);
    rst = 1'b0;
    repeat (10 - at - len) @(negedge clk);
    bus.sensor = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  int bnd [10] = '{4, 7, 8, 15, 16, 19, 20, 31, 32, 33};

  initial begin
    for (int i = 0; i < NCYC; i++) exp_busy[i] = -1;
    bus.sensor = 1'b0;
    mon_en = 1'b1;

    // reset held while the sensor toggles
    repeat (10) begin
      @(negedge clk);
      bus.sensor = 1'($urandom_range(0, 1));
      chk("busy_rst", int'(bus.busy), 0);
    end
    @(negedge clk);
    bus.sensor = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    pulse(10, 14);
    pulse(25, 12);
    pulse(8, 14);
    pulse(3, 14);
    pulse(17, 14);
    pulse(40, 14);
    reset_pulse(5, 3);
    reset_pulse(7, 1);
    pulse(10, 14);
    foreach (bnd[i]) pulse(bnd[i], 14);
    repeat (25) pulse($urandom_range(1, 45), $urandom_range(12, 20));

    repeat (4) @(negedge clk);
    chk("busy_end", int'(bus.busy), 0);
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
